datapath: RTL and testbench



---
 rtl/datapath.sv | 127 ++++++++++++
 tb/tb_datapath.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// Single-cycle R-type MIPS datapath: PC, instruction memory, 32x32 register file, ALU.
// Define DATAPATH_IMM_EN to also execute I-type addi/ori (destination rt, immediate B operand).

module datapath_imem #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] addr_i,
  output logic [31:0]   instr_o
);
  logic [31:0] imem [0:DEPTH-1];

  // Host load port; contents are normally preloaded from outside.
  always_ff @(posedge clk_i)
    if (we_i) imem[waddr_i] <= wdata_i;

  assign instr_o = imem[addr_i];
endmodule

module datapath_rf (
  input  logic        clk_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o,
  input  logic        we_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i
);
  logic [31:0] regArray [0:31];

  always_ff @(posedge clk_i)
    if (we_i && (wa_i != 5'd0)) regArray[wa_i] <= wd_i;

  assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : regArray[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : regArray[ra2_i];
endmodule

module datapath #(
  parameter int IMEM_DEPTH = 64,
  parameter int PC_STEP    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] Dout
);
  localparam int          AW      = $clog2(IMEM_DEPTH);
  localparam logic [31:0] PC_MASK = 32'(IMEM_DEPTH * 4 - 1);

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_SLT} alu_op_e;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr, rs_val, rt_val, b_op, alu_res;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, dst;
  logic        valid;
  alu_op_e     alu_op;

  assign pc_d = (pc_q + 32'(PC_STEP)) & PC_MASK;

  always_ff @(posedge clk)
    if (reset) pc_q <= 32'd0;
    else       pc_q <= pc_d;

  datapath_imem #(.DEPTH(IMEM_DEPTH)) im (
    .clk_i(clk), .we_i(1'b0), .waddr_i('0), .wdata_i(32'd0),
    .addr_i(pc_q[AW+1:2]), .instr_o(instr)
  );

  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign funct = instr[5:0];

  logic unused_bits;
  assign unused_bits = ^{pc_q[31:AW+2], pc_q[1:0], instr[10:6]};

  datapath_rf rf (
    .clk_i(clk), .ra1_i(rs), .ra2_i(rt), .rd1_o(rs_val), .rd2_o(rt_val),
    .we_i(valid && !reset), .wa_i(dst), .wd_i(alu_res)
  );

  // An unknown or unsupported word falls into a default arm and stays invalid.
  always_comb begin
    valid  = 1'b0;
    alu_op = ALU_ADD;
    dst    = rd;
    b_op   = rt_val;
    case (op)
      6'h00:
        case (funct)
          6'h20: begin valid = 1'b1; alu_op = ALU_ADD; end
          6'h22: begin valid = 1'b1; alu_op = ALU_SUB; end
          6'h24: begin valid = 1'b1; alu_op = ALU_AND; end
          6'h25: begin valid = 1'b1; alu_op = ALU_OR;  end
          6'h27: begin valid = 1'b1; alu_op = ALU_NOR; end
          6'h2A: begin valid = 1'b1; alu_op = ALU_SLT; end
          default: ;
        endcase
`ifdef DATAPATH_IMM_EN
      6'h08: begin valid = 1'b1; alu_op = ALU_ADD; dst = rt; b_op = {{16{instr[15]}}, instr[15:0]}; end
      6'h0D: begin valid = 1'b1; alu_op = ALU_OR;  dst = rt; b_op = {16'd0, instr[15:0]}; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    alu_res = 32'd0;
    case (alu_op)
      ALU_ADD: alu_res = rs_val + b_op;
      ALU_SUB: alu_res = rs_val - b_op;
      ALU_AND: alu_res = rs_val & b_op;
      ALU_OR:  alu_res = rs_val | b_op;
      ALU_NOR: alu_res = ~(rs_val | b_op);
      ALU_SLT: alu_res = {31'd0, $signed(rs_val) < $signed(b_op)};
      default: alu_res = 32'd0;
    endcase
  end

  assign Dout = (!reset && valid) ? alu_res : 32'd0;
endmodule

// File: tb/tb_datapath.sv
// Bench for datapath: directed lab programs plus a random program against a register-image model.
module tb_datapath;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Dout;

  datapath #(.IMEM_DEPTH(DEPTH), .PC_STEP(4)) dut (.clk(clk), .reset(reset), .Dout(Dout));

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] mreg  [32];
  logic [31:0] mimem [DEPTH];
  int          mpc;

  function automatic logic [31:0] R(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  // Architectural effect of one instruction on the model register image.
  function automatic void mexec(input logic [31:0] ins, output logic v, output int d,
                                output logic [31:0] res);
    logic [31:0] a, b;
    a = mreg[ins[25:21]];
    b = mreg[ins[20:16]];
    v = 1'b1; d = int'(ins[15:11]); res = 32'd0;
    if (ins[31:26] == 6'h00) begin
      case (ins[5:0])
        6'h20: res = a + b;
        6'h22: res = a - b;
        6'h24: res = a & b;
        6'h25: res = a | b;
        6'h27: res = ~(a | b);
        6'h2A: res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
        default: v = 1'b0;
      endcase
`ifdef DATAPATH_IMM_EN
    end else if (ins[31:26] == 6'h08) begin
      d = int'(ins[20:16]); res = a + {{16{ins[15]}}, ins[15:0]};
    end else if (ins[31:26] == 6'h0D) begin
      d = int'(ins[20:16]); res = a | {16'd0, ins[15:0]};
`endif
    end else v = 1'b0;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] fn [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    int k = $urandom_range(0, 11);
    logic [14:0] regs = 15'($urandom);
    if (k < 6)  return {6'd0, regs, 5'd0, fn[k]};
    if (k == 6) return {6'd0, regs, 5'd0, fn[$urandom_range(0, 5)]};
    if (k == 7) return {6'h08, regs[14:5], 16'($urandom)};
    if (k == 8) return {6'h0D, regs[14:5], 16'($urandom)};
    if (k == 9) return {6'd0, regs, 5'd0, 6'h21};
    return $urandom;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_phase(input string tag);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) dut.im.imem[i] = mimem[i];
    for (int i = 0; i < 32; i++) dut.rf.regArray[i] = mreg[i];
    mpc = 0;
    @(posedge clk);
    #1;
    chk({tag, "_rst_pc"}, dut.pc_q, 32'd0);
    chk({tag, "_rst_dout"}, Dout, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic cycle(input string tag);
    logic v; int d; logic [31:0] r;
    #1;
    mexec(mimem[mpc], v, d, r);
    chk(tag, Dout, v ? r : 32'd0);
    @(posedge clk);
    if (v && d != 0) mreg[d] = r;
    mpc = (mpc + 1) % DEPTH;
    @(negedge clk);
  endtask

  task automatic dump(input string tag);
    for (int i = 0; i < 32; i++)
      chk($sformatf("%s_reg%0d", tag, i), dut.rf.regArray[i], mreg[i]);
  endtask

  initial begin
    // add with r1=5, r2=3
    for (int i = 0; i < DEPTH; i++) mimem[i] = 32'hFFFF_FFFF;
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    mreg[1] = 32'd5; mreg[2] = 32'd3;
    mimem[0] = 32'h0022_1820;
    start_phase("A");
    #1 chk("A_add_dout", Dout, 32'd8);
    cycle("A_add");
    chk("A_rf3", dut.rf.regArray[3], 32'h0000_0008);
    cycle("A_unsup");

    // sub / slt with r1=3, r2=5
    for (int i = 0; i < DEPTH; i++) mimem[i] = 32'hFFFF_FFFF;
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    mreg[1] = 32'd3; mreg[2] = 32'd5;
    mimem[0] = R(1, 2, 4, 6'h22);
    mimem[1] = R(1, 2, 5, 6'h2A);
    mimem[2] = R(2, 1, 6, 6'h2A);
    start_phase("B");
    for (int i = 0; i < 3; i++) cycle($sformatf("B_i%0d", i));
    chk("B_rf4", dut.rf.regArray[4], 32'hFFFF_FFFE);
    chk("B_rf5", dut.rf.regArray[5], 32'h0000_0001);
    chk("B_rf6", dut.rf.regArray[6], 32'h0000_0000);

    // logic ops, write to r0, unsupported word
    for (int i = 0; i < DEPTH; i++) mimem[i] = 32'hFFFF_FFFF;
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    mreg[1] = 32'hF0F0_F0F0; mreg[2] = 32'h0FF0_0FF0;
    mimem[0] = R(1, 2, 7, 6'h24);
    mimem[1] = R(1, 2, 8, 6'h25);
    mimem[2] = R(1, 2, 9, 6'h27);
    mimem[3] = R(1, 2, 0, 6'h20);
    start_phase("C");
    for (int i = 0; i < 3; i++) cycle($sformatf("C_i%0d", i));
    #1 chk("C_add0_dout", Dout, 32'h00E1_00E0);
    cycle("C_add0");
    #1 chk("C_unsup_dout", Dout, 32'd0);
    cycle("C_unsup");
    chk("C_rf7", dut.rf.regArray[7], 32'h00F0_00F0);
    chk("C_rf8", dut.rf.regArray[8], 32'hFFF0_FFF0);
    chk("C_rf9", dut.rf.regArray[9], 32'h000F_000F);
    dump("C");

    // random program, full wrap, then reset mid-program
    mreg[0] = 32'd0;
    for (int i = 1; i < 32; i++) mreg[i] = $urandom;
    for (int i = 0; i < DEPTH; i++) mimem[i] = rand_instr();
    start_phase("D");
    for (int i = 0; i <= DEPTH; i++) begin
      if (i == DEPTH) chk("D_pc_wrap", dut.pc_q, 32'd0);
      cycle($sformatf("D_c%0d", i));
    end
    dump("D");
    for (int i = 0; i < 5; i++) cycle($sformatf("E_c%0d", i));
    reset = 1'b1;
    #1 chk("E_rst_dout", Dout, 32'd0);
    @(posedge clk);
    #1 chk("E_rst_pc", dut.pc_q, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    mpc = 0;
    for (int i = 0; i < 8; i++) cycle($sformatf("E_r%0d", i));
    dump("E");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
